testmode_sequencer: RTL and testbench

Controller for the test-signal generator (the frequency-selectable divider driven by `testmode[1:0]`). It selects the frequency code either from the switches or by sweeping all four codes 00→01→10→11. After each code change it waits for the generator output to settle. It then opens a fixed-length measurement gate for the downstream frequency counter and pulses completion with the code that was measured.

---
 rtl/testmode_sequencer.sv | 162 ++++++++++++++++
 tb/tb_testmode_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/testmode_sequencer.sv
// ---------------------------------------------------------------------------
// testmode_sequencer
//
// Drives the frequency code of the test-signal generator and frames one
// measurement window per code for the downstream frequency counter.
// A run measures either the switch-selected code once, or sweeps the codes
// 00 -> 01 -> 10 -> 11. Each code gets a settle interval followed by a gate
// window and then a one-cycle completion pulse that reports the code.
//
// Optional build macro: TESTMODE_SWEEP_REPEAT_EN
//   defined   : an auto sweep wraps from 11 back to 00 and runs until stop/reset
//   undefined : an auto sweep ends after code 11 and returns to IDLE
//
// Ports:
//   sysclk       in   system clock
//   rst_n        in   synchronous active-low reset
//   start        in   level, sampled in IDLE only, begins a run
//   stop         in   level, aborts any run and returns to IDLE
//   auto_en      in   1 = sweep all four codes, 0 = single code (manual_mode)
//   manual_mode  in   [1:0] switch-selected frequency code
//   testmode     out  [1:0] registered frequency code to the generator
//   meas_gate    out  counter enable window
//   meas_done    out  one-cycle pulse at the end of each gate window
//   done_mode    out  [1:0] code just measured, held after the pulse
//   busy         out  high in every state except IDLE
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | testmode tracks manual_mode, waits for start
// SETTLE  | code applied, waiting SETTLE_CYCLES for the generator to settle
// MEASURE | meas_gate high for GATE_CYCLES
// DONE    | one cycle, meas_done high, pick next code or return to IDLE
// ---------------------------------------------------------------------------
module testmode_sequencer #(
    parameter int SETTLE_CYCLES = 4000000,
    parameter int GATE_CYCLES   = 100000000,
    parameter int CNT_W         = 27
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       auto_en,
    input  logic [1:0] manual_mode,
    output logic [1:0] testmode,
    output logic       meas_gate,
    output logic       meas_done,
    output logic [1:0] done_mode,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef TESTMODE_SWEEP_REPEAT_EN
    localparam bit SWEEP_REPEAT = 1'b1;
`else
    localparam bit SWEEP_REPEAT = 1'b0;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             auto_q;
    logic [1:0]       testmode_q;
    logic             meas_gate_q;
    logic             meas_done_q;
    logic [1:0]       done_mode_q;
    logic             busy_q;

    // A sweep continues to the next code unless it has just finished code 11
    // (and the repeat build lets it wrap even then).
    logic sweep_next;
    assign sweep_next = auto_q && (SWEEP_REPEAT || (testmode_q != 2'b11));

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            auto_q      <= 1'b0;
            testmode_q  <= 2'b00;
            meas_gate_q <= 1'b0;
            meas_done_q <= 1'b0;
            done_mode_q <= 2'b00;
            busy_q      <= 1'b0;
        end else if ((state_q != S_IDLE) && stop) begin
            // Abort: truncate any gate window, no completion pulse,
            // testmode is left alone until the next IDLE cycle.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            meas_gate_q <= 1'b0;
            meas_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            meas_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    testmode_q <= manual_mode;
                    if (start && !stop) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        auto_q  <= auto_en;
                        if (auto_en) begin
                            testmode_q <= 2'b00;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q     <= S_MEASURE;
                        cnt_q       <= '0;
                        meas_gate_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_MEASURE: begin
                    if (cnt_q == GATE_LAST) begin
                        state_q     <= S_DONE;
                        cnt_q       <= '0;
                        meas_gate_q <= 1'b0;
                        meas_done_q <= 1'b1;
                        done_mode_q <= testmode_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    cnt_q <= '0;
                    if (sweep_next) begin
                        // 2-bit add wraps 11 -> 00 in the repeat build.
                        testmode_q <= testmode_q + 2'd1;
                        state_q    <= S_SETTLE;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign testmode  = testmode_q;
    assign meas_gate = meas_gate_q;
    assign meas_done = meas_done_q;
    assign done_mode = done_mode_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_testmode_sequencer.sv
module tb_testmode_sequencer;

    localparam int SETTLE = 4;
    localparam int GATE   = 10;
    localparam int SEG    = SETTLE + GATE + 1;

`ifdef TESTMODE_SWEEP_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] manual_mode = 2'b00;
    logic [1:0] testmode;
    logic       meas_gate;
    logic       meas_done;
    logic [1:0] done_mode;
    logic       busy;

    always #5 sysclk = ~sysclk;

    testmode_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .GATE_CYCLES  (GATE),
        .CNT_W        (4)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .auto_en    (auto_en),
        .manual_mode(manual_mode),
        .testmode   (testmode),
        .meas_gate  (meas_gate),
        .meas_done  (meas_done),
        .done_mode  (done_mode),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a run is a sequence of SEG-cycle segments, one per code.
    // Offset k counts edges since the start edge; outputs follow from k.
    bit         m_run;
    int         m_k;
    bit         m_auto;
    logic [1:0] m_base, m_tm, m_dm;
    bit         m_gate, m_done, m_busy;

    initial begin
        m_run = 0; m_k = 0; m_auto = 0; m_base = 0; m_tm = 0; m_dm = 0;
        m_gate = 0; m_done = 0; m_busy = 0;
    end

    task automatic model_edge();
        int p;
        if (!rst_n) begin
            m_run = 0; m_k = 0; m_auto = 0; m_base = 0; m_tm = 0; m_dm = 0;
        end else if (m_run && stop) begin
            m_run = 0;
        end else if (!m_run) begin
            m_tm = manual_mode;
            if (start && !stop) begin
                m_run  = 1;
                m_k    = 0;
                m_auto = auto_en;
                m_base = auto_en ? 2'b00 : manual_mode;
            end
        end else begin
            m_k++;
            if (!(m_auto && REP) && (m_k == SEG * (m_auto ? 4 : 1))) m_run = 0;
        end
        if (m_run) begin
            p      = m_k % SEG;
            m_tm   = m_base + 2'(m_k / SEG);
            m_gate = (p >= SETTLE) && (p < SETTLE + GATE);
            m_done = (p == SEG - 1);
            if (m_done) m_dm = m_tm;
            m_busy = 1;
        end else begin
            m_gate = 0; m_done = 0; m_busy = 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        n_tests++;
        if (testmode !== m_tm || meas_gate !== m_gate || meas_done !== m_done ||
            done_mode !== m_dm || busy !== m_busy) begin
            n_fail++;
            $display("FAIL model_cmp t=%0t: got tm=%b gate=%b done=%b dm=%b busy=%b, expected tm=%b gate=%b done=%b dm=%b busy=%b",
                     $time, testmode, meas_gate, meas_done, done_mode, busy,
                     m_tm, m_gate, m_done, m_dm, m_busy);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic       rst_n, start, stop, auto_en;
        logic [1:0] man;
        logic [1:0] e_tm;
        logic       e_gate, e_done;
        logic [1:0] e_dm;
        logic       e_busy;
    } vec_t;

    vec_t tv[13];

    initial begin
        int rise, high, dn, dmv, dnat, bfall, npulse, last_done, stab_err, extra;
        logic prev_gate;
        logic [1:0] prev_tm;

        //          rst start stop auto man   tm   gate done dm  busy
        tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            rst_n = tv[i].rst_n; start = tv[i].start; stop = tv[i].stop;
            auto_en = tv[i].auto_en; manual_mode = tv[i].man;
            step();
            chk($sformatf("vec%0d_tm", i),   testmode,  tv[i].e_tm);
            chk($sformatf("vec%0d_gate", i), meas_gate, tv[i].e_gate);
            chk($sformatf("vec%0d_done", i), meas_done, tv[i].e_done);
            chk($sformatf("vec%0d_dm", i),   done_mode, tv[i].e_dm);
            chk($sformatf("vec%0d_busy", i), busy,      tv[i].e_busy);
        end

        rst_n = 1; start = 0; stop = 0; auto_en = 0; manual_mode = 0;
        step(); step();

        // Single measurement of code 10.
        manual_mode = 2'd2; start = 1;
        step();
        chk("single_tm_first", testmode, 2);
        chk("single_busy_first", busy, 1);
        start = 0; manual_mode = 2'd1;
        rise = -1; high = 0; dn = 0; dmv = -1; dnat = -1; bfall = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (meas_gate && rise < 0) rise = i;
            if (meas_gate) high++;
            if (meas_done) begin dn++; dmv = done_mode; dnat = i; end
            if (!busy && bfall < 0) bfall = i;
        end
        chk("single_gate_rise", rise, SETTLE);
        chk("single_gate_len", high, GATE);
        chk("single_done_count", dn, 1);
        chk("single_done_mode", dmv, 2);
        chk("single_done_at", dnat, SETTLE + GATE);
        chk("single_busy_fall", bfall, SEG);
        chk("single_idle_tm", testmode, 1);

        // Full sweep.
        auto_en = 1; manual_mode = 2'd2; start = 1;
        step();
        start = 0; auto_en = 0;
        npulse = 0; last_done = 0 - 1; stab_err = 0; prev_gate = 0; prev_tm = testmode;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (meas_gate && prev_gate && testmode != prev_tm) stab_err++;
            prev_gate = meas_gate; prev_tm = testmode;
            if (meas_done) begin
                chk($sformatf("sweep_code%0d", npulse), done_mode, npulse % 4);
                chk($sformatf("sweep_at%0d", npulse), i,
                    (npulse == 0) ? SEG - 1 : last_done + SEG);
                last_done = i;
                npulse++;
                if (REP && npulse == 6) break;
            end
        end
        chk("sweep_gate_stable", stab_err, 0);
        if (REP) begin
            chk("rep_pulses", npulse, 6);
            stop = 1;
            step();
            stop = 0;
            chk("rep_stop_busy", busy, 0);
            chk("rep_stop_gate", meas_gate, 0);
            extra = 0;
            for (int i = 0; i < 20; i++) begin step(); if (meas_done) extra++; end
            chk("rep_no_more_done", extra, 0);
        end else begin
            chk("sweep_pulses", npulse, 4);
            chk("sweep_end_busy", busy, 0);
        end

        // Abort on the 5th gate cycle of code 01.
        auto_en = 1; manual_mode = 2'd2; start = 1;
        step();
        start = 0;
        for (int k = 1; k <= SEG + SETTLE + 4; k++) step();
        chk("abort_pre_gate", meas_gate, 1);
        chk("abort_pre_tm", testmode, 1);
        stop = 1;
        step();
        stop = 0; manual_mode = 2'd3;
        chk("abort_gate", meas_gate, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", meas_done, 0);
        extra = 0;
        step();
        if (meas_done) extra++;
        chk("abort_tm_follow", testmode, 3);
        for (int i = 0; i < 20; i++) begin step(); if (meas_done) extra++; end
        chk("abort_no_done", extra, 0);

        // start re-asserted mid-run does not restart.
        auto_en = 0; manual_mode = 2'd3; start = 1;
        step();
        start = 0;
        dn = 0; dnat = -1;
        for (int i = 1; i <= 20; i++) begin
            start = (i >= 5 && i <= 8);
            step();
            if (meas_done) begin dn++; dnat = i; end
        end
        start = 0;
        chk("midstart_done_count", dn, 1);
        chk("midstart_done_at", dnat, SEG - 1);
        chk("midstart_done_mode", done_mode, 3);

        // Randomised run against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            stop        = ($urandom_range(0, 49) == 0);
            start       = ($urandom_range(0, 3) == 0);
            auto_en     = $urandom_range(0, 1);
            manual_mode = 2'($urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
